sap_universal_register: RTL and testbench
=========================================

// Module: sap_universal_register
// PURPOSE
//  Parametrised successor to the 8-bit 74173-style bus register for the SAP datapath.
//  Adds WIDTH generalisation, single-cycle INC/DEC and multi-cycle shift/rotate by N.
//  Adds carry/zero flags, a start/busy/done handshake and a tri-state bus driver.
//  Serves as the accumulator / B / temp register of the next-generation SAP core.
// PARAMETERS
//  WIDTH      8   data width in bits (>=2)
//  RESET_VAL  0   value loaded into q on reset
//  AMT_W      $clog2(WIDTH)+1   width of shift-amount input (derived, do not override)
// PORTS
//  clk       in   1        rising-edge clock
//  clr       in   1        asynchronous, active-low reset
//  load      in   1        1 = q <= data at next edge (highest priority)
//  enable    in   1        1 = drive bus_out with q, 0 = bus_out high-Z
//  start     in   1        1 in IDLE = begin operation selected by op
//  op        in   3        000 HOLD,001 INC,010 DEC,011 SHL,100 SHR,101 ROL,110 ROR,111 ASR
//  amt       in   AMT_W    shift/rotate step count, sampled with start
//  serial_in in   1        fill bit for SHL (into LSB) and SHR (into MSB)
//  data      in   WIDTH    parallel load value
//  bus_out   out  WIDTH    tri-state copy of q
//  q         out  WIDTH    register contents, always visible
//  carry     out  1        carry/borrow/last bit shifted out
//  zero      out  1        combinational (q == 0)
//  busy      out  1        1 while in SHIFT state
//  done      out  1        one-cycle pulse, operation complete
// BEHAVIOUR
//  Reset (clr=0, async): q=RESET_VAL, carry=0, busy=0, done=0, state=IDLE, step count=0.
//  Reset is effective immediately, regardless of clk. Mid-shift reset aborts; no done.
//  bus_out = enable ? q : {WIDTH{1'bz}}; purely combinational, no latency.
//  Priority at each edge: load > active shift step > start > hold.
//  load: q<=data, carry<=0, state<=IDLE, done<=0; aborts any shift in progress (no done).
//  States: IDLE, SHIFT.
//  IDLE & start & op=HOLD: done pulses next cycle; q and carry unchanged.
//  IDLE & start & op=INC: q<=q+1 (mod 2^WIDTH), carry<=(q=={WIDTH{1}}), done next cycle.
//  IDLE & start & op=DEC: q<=q-1 (mod 2^WIDTH), carry<=(q==0) (borrow), done next cycle.
//  IDLE & start & shift op & amt==0: no change, done next cycle.
//  IDLE & start & shift op & amt>0: latch op and amt, enter SHIFT; busy=1 next cycle.
//  SHIFT: one step per clk. After amt steps: return to IDLE, busy=0, done=1 (same edge).
//  SHIFT occupies exactly amt cycles; start is ignored while busy.
//  Step definitions; carry <= bit shifted out each step:
//   SHL: q<={q[W-2:0],serial_in}, carry<=q[W-1].
//   SHR: q<={serial_in,q[W-1:1]}, carry<=q[0].
//   ROL: q<={q[W-2:0],q[W-1]}, carry<=q[W-1].
//   ROR: q<={q[0],q[W-1:1]}, carry<=q[0].
//   ASR: q<={q[W-1],q[W-1:1]}, carry<=q[0].
//  amt > WIDTH is legal: all amt steps are performed (e.g. SHL fills fully with serial_in).
//  done is registered: high for exactly one cycle, and only after a completed operation.
//  Simultaneous load & start in IDLE: load wins and start is dropped.
// TESTING
//  1 clr=0 asynchronously mid-cycle during SHIFT -> q=0x00, carry=0, busy=0, done stays 0.
//  2 load data=0xA5, enable=1 -> bus_out=0xA5, zero=0; enable=0 -> bus_out=8'hzz, q=0xA5.
//  3 load 0xFF; start op=INC -> q=0x00, carry=1, zero=1, done=1 for one cycle.
//    Then start op=DEC -> q=0xFF, carry=1.
//  4 load 0x81; start op=SHL amt=3 serial_in=0 -> busy 3 cycles, q=0x08, carry=0, done 1 cycle.
//  5 load 0x12; start op=ROR amt=4 -> q=0x21, carry=0 after 4 cycles.
//    Then ASR amt=1 on loaded 0x80 -> q=0xC0, carry=0.
//  6 SHL amt=5 from 0x01; assert load data=0x3C on 2nd busy cycle -> q=0x3C next edge.
//    busy=0, carry=0, no done pulse; start during busy ignored.

Source files
------------

// File: rtl/sap_universal_register.sv
// rtl/sap_universal_register.sv - SAP bus register with INC/DEC, multi-cycle shift/rotate, flags and tri-state bus.
module sap_universal_register #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 AMT_W     = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic               enable,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [AMT_W-1:0]   amt,
  input  logic               serial_in,
  input  logic [WIDTH-1:0]   data,
  output logic [WIDTH-1:0]   bus_out,
  output logic [WIDTH-1:0]   q,
  output logic               carry,
  output logic               zero,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_INC  = 3'd1;
  localparam logic [2:0] OP_DEC  = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_ROL  = 3'd5;
  localparam logic [2:0] OP_ROR  = 3'd6;
  localparam logic [2:0] OP_ASR  = 3'd7;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              carry_q, carry_d;
  logic              done_q, done_d;
  logic [2:0]        op_q, op_d;
  logic [AMT_W-1:0]  cnt_q, cnt_d;

  // One shift/rotate step; result is {bit shifted out, new value}.
  function automatic logic [WIDTH:0] shift_step(input logic [2:0] o,
                                                input logic [WIDTH-1:0] v,
                                                input logic s);
    logic [WIDTH:0] r;
    case (o)
      OP_SHL:  r = {v[WIDTH-1], v[WIDTH-2:0], s};
      OP_SHR:  r = {v[0], s, v[WIDTH-1:1]};
      OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  r = {v[0], v[0], v[WIDTH-1:1]};
      OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: r = {1'b0, v};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      q_q     <= RESET_VAL;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= OP_HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    op_d    = op_q;
    cnt_d   = cnt_q;
    if (load) begin
      q_d     = data;
      carry_d = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      {carry_d, q_d} = shift_step(op_q, q_q, serial_in);
      cnt_d = cnt_q - AMT_W'(1);
      if (cnt_q == AMT_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (start) begin
      case (op)
        OP_HOLD: done_d = 1'b1;
        OP_INC: begin
          {carry_d, q_d} = {1'b0, q_q} + (WIDTH+1)'(1);
          done_d         = 1'b1;
        end
        OP_DEC: begin
          carry_d = (q_q == '0);
          q_d     = q_q - WIDTH'(1);
          done_d  = 1'b1;
        end
        default: begin
          if (amt == '0) begin
            done_d = 1'b1;
          end else begin
            op_d    = op;
            cnt_d   = amt;
            state_d = SHIFT;
          end
        end
      endcase
    end
  end

  assign q       = q_q;
  assign carry   = carry_q;
  assign zero    = (q_q == '0);
  assign busy    = (state_q == SHIFT);
  assign done    = done_q;
  assign bus_out = enable ? q_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_sap_universal_register.sv
// tb/tb_sap_universal_register.sv - randomized self-checking bench against an arithmetic reference model.
module tb_sap_universal_register;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [3:0] amt = 4'd0;
  logic       serial_in = 1'b0;
  logic [7:0] data = 8'd0;
  wire  [7:0] bus_out;
  wire  [7:0] q;
  wire        carry;
  wire        zero;
  wire        busy;
  wire        done;

  int vectors = 0;
  int miscompares = 0;
  int mq = 0;
  int mc = 0;

  sap_universal_register dut (
    .clk(clk), .clr(clr), .load(load), .enable(enable), .start(start),
    .op(op), .amt(amt), .serial_in(serial_in), .data(data),
    .bus_out(bus_out), .q(q), .carry(carry), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: value treated as an integer in [0,255], shifts as multiply/divide by two.
  task automatic model_op(input int o, input int a, input int s);
    int msb;
    case (o)
      1: begin mc = (mq == 255); mq = (mq + 1) % 256; end
      2: begin mc = (mq == 0); mq = (mq + 255) % 256; end
      default: begin
        for (int k = 0; k < a && o >= 3; k++) begin
          msb = mq / 128;
          case (o)
            3: begin mc = msb; mq = (mq * 2) % 256 + s; end
            4: begin mc = mq % 2; mq = mq / 2 + s * 128; end
            5: begin mc = msb; mq = (mq * 2) % 256 + msb; end
            6: begin mc = mq % 2; mq = mq / 2 + mc * 128; end
            default: begin mc = mq % 2; mq = mq / 2 + msb * 128; end
          endcase
        end
      end
    endcase
  endtask

  task automatic do_load(input logic [7:0] d);
    @(negedge clk);
    load = 1'b1; data = d;
    @(posedge clk); #1;
    load = 1'b0;
    mq = d; mc = 0;
  endtask

  task automatic run_op(input int o, input int a, input int s);
    int cyc;
    int busy_cnt;
    int exp_busy;
    @(negedge clk);
    start = 1'b1; op = o[2:0]; amt = a[3:0]; serial_in = s[0];
    @(posedge clk); #1;
    start = 1'b0;
    model_op(o, a, s);
    exp_busy = (o >= 3) ? a : 0;
    busy_cnt = 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    vectors++;
    if (cyc >= 40) begin miscompares++; $display("FAIL op%0d amt%0d done_timeout: got no done, want done", o, a); end
    vectors++;
    if (busy_cnt !== exp_busy) begin miscompares++; $display("FAIL op%0d amt%0d busy_cycles: got %0d want %0d", o, a, busy_cnt, exp_busy); end
    vectors++;
    if (q !== mq[7:0]) begin miscompares++; $display("FAIL op%0d amt%0d q: got %h want %h", o, a, q, mq[7:0]); end
    vectors++;
    if (carry !== mc[0]) begin miscompares++; $display("FAIL op%0d amt%0d carry: got %b want %b", o, a, carry, mc[0]); end
    vectors++;
    if (zero !== (mq == 0)) begin miscompares++; $display("FAIL op%0d amt%0d zero: got %b want %b", o, a, zero, (mq == 0)); end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL op%0d amt%0d done_pulse: got done=%b busy=%b want 0 0", o, a, done, busy); end
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if (q !== 8'h00 || carry !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL reset: got q=%h c=%b busy=%b done=%b want 00 0 0 0", q, carry, busy, done);
    end
    vectors++;
    if (zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero: got %b want 1", zero); end
    @(negedge clk);
    clr = 1'b1;
    mq = 0; mc = 0;
  endtask

  task automatic test_bus;
    do_load(8'hA5);
    enable = 1'b1; #1;
    vectors++;
    if (bus_out !== 8'hA5 || zero !== 1'b0) begin miscompares++; $display("FAIL bus_drive: got bus=%h zero=%b want a5 0", bus_out, zero); end
    enable = 1'b0; #1;
    vectors++;
    if (bus_out === 8'hA5) begin miscompares++; $display("FAIL bus_release: got %h still driven, want released", bus_out); end
    vectors++;
    if (q !== 8'hA5) begin miscompares++; $display("FAIL bus_q: got %h want a5", q); end
  endtask

  task automatic test_inc_dec;
    do_load(8'hFF);
    run_op(1, 0, 0);
    run_op(2, 0, 0);
    run_op(2, 0, 0);
    run_op(0, 0, 0);
    do_load(8'h00);
    run_op(2, 0, 0);
  endtask

  task automatic test_shift_rotate;
    do_load(8'h81);
    run_op(3, 3, 0);
    do_load(8'h12);
    run_op(6, 4, 0);
    do_load(8'h80);
    run_op(7, 1, 0);
    do_load(8'h5A);
    run_op(4, 0, 1);
    do_load(8'h00);
    run_op(3, 12, 1);
  endtask

  task automatic test_load_abort;
    int cyc;
    do_load(8'h01);
    @(negedge clk);
    start = 1'b1; op = 3'd3; amt = 4'd5; serial_in = 1'b0;
    @(posedge clk); #1;
    op = 3'd1;
    @(posedge clk); #1;
    vectors++;
    if (q !== 8'h02 || busy !== 1'b1) begin miscompares++; $display("FAIL busy_ignores_start: got q=%h busy=%b want 02 1", q, busy); end
    start = 1'b0;
    @(negedge clk);
    load = 1'b1; data = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
    mq = 8'h3C; mc = 0;
    vectors++;
    if (q !== 8'h3C || busy !== 1'b0 || carry !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL load_abort: got q=%h busy=%b c=%b done=%b want 3c 0 0 0", q, busy, carry, done);
    end
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) cyc++;
    end
    vectors++;
    if (cyc !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses want 0", cyc); end
    vectors++;
    if (q !== 8'h3C) begin miscompares++; $display("FAIL abort_hold: got %h want 3c", q); end
  endtask

  task automatic test_back_to_back;
    int d;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        d = $urandom_range(0, 255);
        do_load(d[7:0]);
      end else begin
        run_op($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 1));
      end
    end
  endtask

  task automatic test_async_reset;
    do_load(8'h81);
    @(negedge clk);
    start = 1'b1; op = 3'd3; amt = 4'd5; serial_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    clr = 1'b0; #1;
    vectors++;
    if (q !== 8'h00 || carry !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL async_reset: got q=%h c=%b busy=%b done=%b want 00 0 0 0", q, carry, busy, done);
    end
    @(negedge clk);
    clr = 1'b1;
    mq = 0; mc = 0;
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h00) begin
      miscompares++; $display("FAIL async_reset_after: got done=%b busy=%b q=%h want 0 0 00", done, busy, q);
    end
  endtask

  task automatic test_load_start_same;
    do_load(8'h10);
    @(negedge clk);
    load = 1'b1; data = 8'h77; start = 1'b1; op = 3'd1;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
    mq = 8'h77; mc = 0;
    @(posedge clk); #1;
    vectors++;
    if (q !== 8'h77 || done !== 1'b0) begin miscompares++; $display("FAIL load_beats_start: got q=%h done=%b want 77 0", q, done); end
  endtask

  initial begin
    test_reset;
    test_bus;
    test_inc_dec;
    test_shift_rotate;
    test_load_abort;
    test_load_start_same;
    test_back_to_back;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
